dma_sched: RTL



---
 rtl/dma_sched_if.sv | 37 +++
 rtl/dma_sched.sv | 121 ++++++++++++
 2 files changed

// File: rtl/dma_sched_if.sv
// Bundles the requester handshakes and the DMA command port of the rotate-engine scheduler.
// The slave modport is the scheduler's view; the master modport is the requesters' and DMA's view.
interface dma_sched_if #(
  parameter int LEN_W = 16
);
  logic             rd_req;
  logic [31:0]      rd_addr;
  logic [LEN_W-1:0] rd_len;
  logic             rd_ack;
  logic             rd_done;

  logic             wr_req;
  logic [31:0]      wr_addr;
  logic [LEN_W-1:0] wr_len;
  logic             wr_ack;
  logic             wr_done;

  logic             dma_start;
  logic             dma_write;
  logic [31:0]      dma_addr;
  logic [5:0]       dma_count;
  logic [2:0]       dma_size;
  logic             dma_busy;
  logic             idle;

  modport slave (
    input  rd_req, rd_addr, rd_len, wr_req, wr_addr, wr_len, dma_busy,
    output rd_ack, rd_done, wr_ack, wr_done,
    output dma_start, dma_write, dma_addr, dma_count, dma_size, idle
  );

  modport master (
    output rd_req, rd_addr, rd_len, wr_req, wr_addr, wr_len, dma_busy,
    input  rd_ack, rd_done, wr_ack, wr_done,
    input  dma_start, dma_write, dma_addr, dma_count, dma_size, idle
  );
endinterface

// File: rtl/dma_sched.sv
// Shares one DMA port between read and write channels, splitting requests into bursts.
// Define DMA_SCHED_WR_PRIO_EN to make write win every contended grant instead of round-robin.
module dma_sched #(
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  dma_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state;
  logic [31:0]      cur_addr;
  logic [LEN_W-1:0] remaining;
  logic             grant_wr;
  logic             pick_wr;
  logic [8:0]       room;
  logic [8:0]       limit;
  logic [5:0]       chunk;

`ifdef DMA_SCHED_WR_PRIO_EN
  always_comb begin
    pick_wr = bus.wr_req;
  end
`else
  logic last_wr;

  always_comb begin
    pick_wr = bus.wr_req;
    if (bus.wr_req && bus.rd_req) pick_wr = !last_wr;
  end
`endif

  // Words left before the next 1 KB boundary; address low bits are always zero.
  always_comb begin
    room  = 9'd256 - {1'b0, cur_addr[9:2]};
    limit = (room < 9'(MAX_BURST)) ? room : 9'(MAX_BURST);
    chunk = (32'(remaining) < 32'(limit)) ? remaining[5:0] : limit[5:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      grant_wr      <= 1'b0;
`ifndef DMA_SCHED_WR_PRIO_EN
      last_wr       <= 1'b1;
`endif
      bus.rd_ack    <= 1'b0;
      bus.rd_done   <= 1'b0;
      bus.wr_ack    <= 1'b0;
      bus.wr_done   <= 1'b0;
      bus.dma_start <= 1'b0;
      bus.dma_write <= 1'b0;
      bus.dma_addr  <= '0;
      bus.dma_count <= '0;
      bus.dma_size  <= 3'b010;
      bus.idle      <= 1'b1;
    end else begin
      bus.rd_ack    <= 1'b0;
      bus.rd_done   <= 1'b0;
      bus.wr_ack    <= 1'b0;
      bus.wr_done   <= 1'b0;
      bus.dma_start <= 1'b0;
      bus.dma_size  <= 3'b010;
      case (state)
        IDLE: begin
          if (bus.rd_req || bus.wr_req) begin
            grant_wr  <= pick_wr;
`ifndef DMA_SCHED_WR_PRIO_EN
            last_wr   <= pick_wr;
`endif
            cur_addr  <= (pick_wr ? bus.wr_addr : bus.rd_addr) & ~32'd3;
            remaining <= pick_wr ? bus.wr_len : bus.rd_len;
            if (pick_wr) bus.wr_ack <= 1'b1;
            else         bus.rd_ack <= 1'b1;
            bus.idle  <= 1'b0;
            state     <= ISSUE;
          end
        end
        // A zero-length request finishes here without ever touching the DMA.
        ISSUE: begin
          if (remaining == '0) begin
            if (grant_wr) bus.wr_done <= 1'b1;
            else          bus.rd_done <= 1'b1;
            bus.idle <= 1'b1;
            state    <= IDLE;
          end else begin
            bus.dma_start <= 1'b1;
            bus.dma_addr  <= cur_addr;
            bus.dma_count <= chunk;
            bus.dma_write <= grant_wr;
            state         <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!bus.dma_start && bus.dma_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!bus.dma_busy) begin
            cur_addr  <= cur_addr + {24'd0, bus.dma_count, 2'b00};
            remaining <= remaining - LEN_W'(bus.dma_count);
            if (remaining == LEN_W'(bus.dma_count)) begin
              if (grant_wr) bus.wr_done <= 1'b1;
              else          bus.rd_done <= 1'b1;
              bus.idle <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
